lsu_access_ctrl: RTL and testbench
==================================

# lsu_access_ctrl

Sequencer for the load/store unit's data-side accesses. It accepts one load or store from the pipeline, decodes the target region, and drives the matching device. Devices are input peripheral, output peripheral, or a variable-latency SRAM with a req/ack handshake. It returns a registered load word with a done pulse, plus an error flag for unmapped, illegal or timed-out accesses. It sits between the LSU request stage and the load-data return mux.

## Interface
Parameters:
- TIMEOUT, 16, max cycles to wait for i_sram_ack before aborting (≥1)
- SRAM_AW, 13, SRAM word-byte address width (addr[12:0])

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req  in  1  access request; sampled only when o_ready=1
- i_we  in  1  1=store, 0=load
- i_addr  in  32  byte address
- i_wdata  in  32  store data
- i_bmask  in  4  store byte enables
- o_ready  out  1  1 only in IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done
- o_ld_data  out  32  load word, valid with o_done (0 on store or error)
- o_sram_req  out  1  SRAM request, held until ack or timeout
- o_sram_we  out  1  SRAM write
- o_sram_addr  out  SRAM_AW  i_addr[SRAM_AW-1:0], latched
- o_sram_wdata  out  32  latched store data
- o_sram_bmask  out  4  latched byte enables
- i_sram_ack  in  1  SRAM completion; honoured only in SRAM_WAIT
- i_sram_rdata  in  32  SRAM read data, valid with ack
- o_op_we  out  1  output-peripheral write strobe, one cycle
- o_per_addr  out  6  latched addr[5:0] for both peripherals
- o_op_wdata  out  32  latched store data
- o_op_bmask  out  4  latched byte enables
- i_op_rdata  in  32  output-peripheral readback
- i_ip_rdata  in  32  input-peripheral read data

## Operation
Region decode uses i_addr[15:0]:
- IP: 0x7800–0x783F (addr[15]=0, [14:11]=1111, [10:6]=0)
- OP: 0x7000–0x703F (addr[15]=0, [14:12]=111, [11:6]=0)
- SRAM: 0x2000–0x3FFF (addr[15:13]=001)
- Everything else is unmapped.

Error cases are a store to IP and any unmapped access.

Request handling:
- Accept = o_ready & i_req.
- On accept, latch we/addr/wdata/bmask and the decoded region.

FSM states: IDLE, PERIPH, SRAM_WAIT, RESP.
- IDLE: accept to SRAM goes to SRAM_WAIT. Accept to IP or OP goes to PERIPH. Accept to unmapped, or a store to IP, goes to RESP with err=1.
- PERIPH: one cycle. Stores to OP assert o_op_we. Loads capture i_ip_rdata or i_op_rdata into the data register. Then go to RESP.
- SRAM_WAIT: o_sram_req=1 and the timeout counter increments each cycle.
  - i_sram_ack=1: capture i_sram_rdata on loads, then go to RESP.
  - Otherwise, when the counter reaches TIMEOUT, go to RESP with err=1 and data 0.
- RESP: o_done=1, o_err as set, then go to IDLE.

Counter and data rules:
- The counter is cleared on accept and is $clog2(TIMEOUT+1) bits wide; it must not wrap.
- o_ld_data holds its value until the next capture and is 0 for stores and errors.

Boundary conditions:
- i_req while not ready: ignored; the requester holds.
- Ack in the same cycle the counter hits TIMEOUT: the ack wins, no error.
- Ack outside SRAM_WAIT: ignored.
- Reset mid-access: next edge goes to IDLE; o_sram_req, o_op_we, o_done and o_err drop; a late ack is ignored.

## Timing
Reset values:
- state IDLE, o_ready=1
- o_done, o_err, o_sram_req, o_sram_we, o_op_we = 0
- o_ld_data, latched addr/data/bmask = 0

All outputs are registered or decoded from the state register only. No combinational path runs from i_req to o_sram_req.

Latency, with accept at edge T:
- IP/OP access: o_op_we high in cycle T+1, o_done in T+2.
- Unmapped or illegal access: o_done with err in T+1.
- SRAM access: o_sram_req high from T+1. An ack sampled at edge A gives o_done in A+1, so the minimum is T+2. A timeout gives o_done in T+TIMEOUT+2.

o_ready returns in the cycle after o_done. The next accept can occur then, giving a peripheral throughput of 1 access per 3 cycles.

## Test plan
- Load 0x7804, i_ip_rdata=0xA5A5_0001 -> o_done at T+2, o_ld_data=0xA5A5_0001, o_err=0, o_sram_req never high.
- Store 0x7010, wdata=0x0000_00FF, bmask=0001 -> o_op_we one cycle at T+1, o_per_addr=0x10, o_done at T+2, o_ld_data=0.
- Load 0x2040, ack after 3 wait cycles, rdata=0xDEAD_BEEF -> o_sram_req high 3 cycles, o_sram_addr=0x0040, o_done one cycle after ack with 0xDEAD_BEEF.
- SRAM load with no ack, TIMEOUT=16 -> o_sram_req drops, o_done and o_err=1 at T+18, o_ld_data=0, o_ready next cycle.
- Load 0x5000 (unmapped), then store 0x7800 (to IP) -> each gives o_done and o_err at T+1; no device strobe.
- i_rst during SRAM_WAIT, followed by a late ack -> o_sram_req=0 next edge, IDLE, no o_done; the next request completes normally.

Source files
------------

// File: rtl/lsu_access_ctrl_if.sv
// Pipeline request/response, SRAM and peripheral signals of the LSU access sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/device side.
interface lsu_access_ctrl_if #(
  parameter int SRAM_AW = 13
);
  logic               i_req;
  logic               i_we;
  logic [31:0]        i_addr;
  logic [31:0]        i_wdata;
  logic [3:0]         i_bmask;
  logic               o_ready;
  logic               o_done;
  logic               o_err;
  logic [31:0]        o_ld_data;
  logic               o_sram_req;
  logic               o_sram_we;
  logic [SRAM_AW-1:0] o_sram_addr;
  logic [31:0]        o_sram_wdata;
  logic [3:0]         o_sram_bmask;
  logic               i_sram_ack;
  logic [31:0]        i_sram_rdata;
  logic               o_op_we;
  logic [5:0]         o_per_addr;
  logic [31:0]        o_op_wdata;
  logic [3:0]         o_op_bmask;
  logic [31:0]        i_op_rdata;
  logic [31:0]        i_ip_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_bmask, i_sram_ack, i_sram_rdata,
           i_op_rdata, i_ip_rdata,
    output o_ready, o_done, o_err, o_ld_data, o_sram_req, o_sram_we, o_sram_addr,
           o_sram_wdata, o_sram_bmask, o_op_we, o_per_addr, o_op_wdata, o_op_bmask
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_bmask, i_sram_ack, i_sram_rdata,
           i_op_rdata, i_ip_rdata,
    input  o_ready, o_done, o_err, o_ld_data, o_sram_req, o_sram_we, o_sram_addr,
           o_sram_wdata, o_sram_bmask, o_op_we, o_per_addr, o_op_wdata, o_op_bmask
  );
endinterface

// File: rtl/lsu_access_ctrl.sv
// LSU data-side sequencer: decodes one load/store into IP, OP or SRAM and returns a registered
// load word with a done pulse; unmapped, IP-store and SRAM-timeout accesses complete with err.
module lsu_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int SRAM_AW = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lsu_access_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PERIPH, SRAM_WAIT, RESP} state_t;
  typedef enum logic [1:0] {RG_IP, RG_OP, RG_SRAM, RG_NONE} region_t;

  state_t             state_q, state_d;
  region_t            region_q, region_d, dec;
  logic               we_q, we_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         bmask_q, bmask_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Upper address bits take no part in region decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.i_addr[31:16];

  always_comb begin
    dec = RG_NONE;
    if (bus.i_addr[15:6] == 10'h1E0)      dec = RG_IP;
    else if (bus.i_addr[15:6] == 10'h1C0) dec = RG_OP;
    else if (bus.i_addr[15:13] == 3'b001) dec = RG_SRAM;
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          we_d     = bus.i_we;
          addr_d   = bus.i_addr[SRAM_AW-1:0];
          wdata_d  = bus.i_wdata;
          bmask_d  = bus.i_bmask;
          region_d = dec;
          cnt_d    = '0;
          data_d   = '0;
          err_d    = 1'b0;
          case (dec)
            RG_SRAM: state_d = SRAM_WAIT;
            RG_OP:   state_d = PERIPH;
            RG_IP: begin
              if (bus.i_we) begin
                err_d   = 1'b1;
                state_d = RESP;
              end else begin
                state_d = PERIPH;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = RESP;
            end
          endcase
        end
      end
      PERIPH: begin
        if (!we_q) data_d = (region_q == RG_IP) ? bus.i_ip_rdata : bus.i_op_rdata;
        state_d = RESP;
      end
      SRAM_WAIT: begin
        // An ack arriving on the final counted cycle still wins over the timeout.
        if (bus.i_sram_ack) begin
          if (!we_q) data_d = bus.i_sram_rdata;
          state_d = RESP;
        end else if (cnt_q == TO_VAL) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      region_q <= RG_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_ready      = (state_q == IDLE);
  assign bus.o_done       = (state_q == RESP);
  assign bus.o_err        = (state_q == RESP) && err_q;
  assign bus.o_ld_data    = data_q;
  assign bus.o_sram_req   = (state_q == SRAM_WAIT);
  assign bus.o_sram_we    = (state_q == SRAM_WAIT) && we_q;
  assign bus.o_sram_addr  = addr_q;
  assign bus.o_sram_wdata = wdata_q;
  assign bus.o_sram_bmask = bmask_q;
  assign bus.o_op_we      = (state_q == PERIPH) && we_q && (region_q == RG_OP);
  assign bus.o_per_addr   = addr_q[5:0];
  assign bus.o_op_wdata   = wdata_q;
  assign bus.o_op_bmask   = bmask_q;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Table-driven bench for lsu_access_ctrl with a completion scoreboard and hand-written
// sequences for held requests, stray acks and reset in the middle of an SRAM wait.
module tb_lsu_access_ctrl;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_access_ctrl_if #(.SRAM_AW(13)) bus ();
  lsu_access_ctrl #(.TIMEOUT(TIMEOUT), .SRAM_AW(13)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          ack_n;
    logic [31:0] ip_d;
    logic [31:0] op_d;
    logic [31:0] sr_d;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_sreq;
    int          exp_opwe;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          done_cyc;
    int          sreq;
    int          opwe;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[15];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_sreq = 0;
  int          n_opwe = 0;
  logic        prev_done = 1'b0;
  logic [12:0] exp_saddr;
  logic [5:0]  exp_paddr;
  logic        exp_swe;
  logic [31:0] exp_wd;
  logic [3:0]  exp_bm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe contents checked every cycle they are high, completions against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      n_sreq    = 0;
      n_opwe    = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", bus.o_ready, 1);
      if (bus.o_sram_req) begin
        n_sreq++;
        chk("sram_addr", bus.o_sram_addr, exp_saddr);
        chk("sram_we", bus.o_sram_we, exp_swe);
        chk("sram_bmask", bus.o_sram_bmask, exp_bm);
      end
      if (bus.o_op_we) begin
        n_opwe++;
        chk("per_addr", bus.o_per_addr, exp_paddr);
        chk("op_wdata", bus.o_op_wdata, exp_wd);
        chk("op_bmask", bus.o_op_bmask, exp_bm);
      end
      if (bus.o_done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: o_done=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_err", bus.o_err, e.err);
          chk("done_data", bus.o_ld_data, e.data);
          chk("done_cycle", cyc, e.done_cyc);
          chk("sram_req_cycles", n_sreq, e.sreq);
          chk("op_we_cycles", n_opwe, e.opwe);
        end
        n_sreq = 0;
        n_opwe = 0;
      end
      prev_done = bus.o_done;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.o_ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ready_within_bound", bus.o_ready, 1);
  endtask

  // Called at #1 after an edge with the DUT idle; accept happens on the next edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    bus.i_we         = v.we;
    bus.i_addr       = v.addr;
    bus.i_wdata      = v.wdata;
    bus.i_bmask      = v.bmask;
    bus.i_ip_rdata   = v.ip_d;
    bus.i_op_rdata   = v.op_d;
    bus.i_sram_rdata = v.sr_d;
    exp_saddr        = v.addr[12:0];
    exp_paddr        = v.addr[5:0];
    exp_swe          = v.we;
    exp_wd           = v.wdata;
    exp_bm           = v.bmask;
    bus.i_req        = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req  = 1'b0;
    e.err      = v.exp_err;
    e.data     = v.exp_data;
    e.done_cyc = cyc + v.exp_lat;
    e.sreq     = v.exp_sreq;
    e.opwe     = v.exp_opwe;
    sb.push_back(e);
    if (v.ack_n > 0) begin
      repeat (v.ack_n - 1) @(posedge clk);
      #1;
      bus.i_sram_ack = 1'b1;
      @(posedge clk);
      #1;
      bus.i_sram_ack = 1'b0;
    end
    wait_ready();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // we, addr, wdata, bmask, ack_n, ip, op, sram, err, data, lat, sreq, opwe
    vecs[0]  = '{1'b0, 32'h0000_7804, 32'h0, 4'h0, 0, 32'hA5A5_0001, 32'h0BBB_0002, 32'h0, 1'b0, 32'hA5A5_0001, 1, 0, 0};
    vecs[1]  = '{1'b1, 32'h0000_7010, 32'h0000_00FF, 4'h1, 0, 32'h1, 32'h2, 32'h3, 1'b0, 32'h0, 1, 0, 1};
    vecs[2]  = '{1'b0, 32'h0000_7020, 32'h0, 4'h0, 0, 32'h1111_0000, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 1, 0, 0};
    vecs[3]  = '{1'b0, 32'h0000_2040, 32'h0, 4'h0, 3, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 3, 0};
    vecs[4]  = '{1'b0, 32'hFFFF_3FFC, 32'h0, 4'h0, 1, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1, 1, 0};
    vecs[5]  = '{1'b1, 32'h0000_2100, 32'h55AA_55AA, 4'hC, 2, 32'h0, 32'h0, 32'h7777_7777, 1'b0, 32'h0, 2, 2, 0};
    vecs[6]  = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 32'h0, 32'h0, 32'h9999_9999, 1'b1, 32'h0, TIMEOUT + 1, TIMEOUT + 1, 0};
    vecs[7]  = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, TIMEOUT + 1, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, TIMEOUT + 1, TIMEOUT + 1, 0};
    vecs[8]  = '{1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 32'h4444_4444, 32'h5555_5555, 32'h0, 1'b1, 32'h0, 0, 0, 0};
    vecs[9]  = '{1'b1, 32'h0000_7800, 32'hFFFF_FFFF, 4'hF, 0, 32'h4444_4444, 32'h5555_5555, 32'h0, 1'b1, 32'h0, 0, 0, 0};
    vecs[10] = '{1'b0, 32'h0000_7840, 32'h0, 4'h0, 0, 32'h4444_4444, 32'h5555_5555, 32'h0, 1'b1, 32'h0, 0, 0, 0};
    vecs[11] = '{1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 0, 32'h4444_4444, 32'h5555_5555, 32'h0, 1'b1, 32'h0, 0, 0, 0};
    vecs[12] = '{1'b0, 32'h0000_783C, 32'h0, 4'h0, 0, 32'h600D_CAFE, 32'h0BAD_0BAD, 32'h0, 1'b0, 32'h600D_CAFE, 1, 0, 0};
    vecs[13] = '{1'b1, 32'h0000_703F, 32'h8765_4321, 4'hF, 0, 32'h1, 32'h2, 32'h0, 1'b0, 32'h0, 1, 0, 1};
    vecs[14] = '{1'b0, 32'h0000_7000, 32'h0, 4'h0, 0, 32'h3333_3333, 32'h0000_00A5, 32'h0, 1'b0, 32'h0000_00A5, 1, 0, 0};

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_bmask = '0;
    bus.i_sram_ack = 1'b0; bus.i_sram_rdata = '0; bus.i_op_rdata = '0; bus.i_ip_rdata = '0;
    exp_saddr = '0; exp_paddr = '0; exp_swe = 1'b0; exp_wd = '0; exp_bm = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_sram_req", bus.o_sram_req, 0);
    chk("rst_sram_we", bus.o_sram_we, 0);
    chk("rst_op_we", bus.o_op_we, 0);
    chk("rst_ld_data", bus.o_ld_data, 0);
    chk("rst_sram_addr", bus.o_sram_addr, 0);
    chk("rst_per_addr", bus.o_per_addr, 0);
    chk("rst_sram_wdata", bus.o_sram_wdata, 0);
    chk("rst_sram_bmask", bus.o_sram_bmask, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Request held high (with different contents) while an SRAM load is in flight.
    bus.i_we = 1'b0; bus.i_addr = 32'h0000_2080; bus.i_sram_rdata = 32'h1357_9BDF;
    exp_saddr = 13'h0080; exp_swe = 1'b0; exp_bm = 4'h0; bus.i_bmask = 4'h0;
    bus.i_req = 1'b1;
    @(posedge clk);
    #1;
    e.err = 1'b0; e.data = 32'h1357_9BDF; e.done_cyc = cyc + 4; e.sreq = 4; e.opwe = 0;
    sb.push_back(e);
    bus.i_we = 1'b1; bus.i_addr = 32'h0000_5000; bus.i_bmask = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    bus.i_sram_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.i_sram_ack = 1'b0;
    bus.i_req = 1'b0;
    wait_ready();

    // Ack while idle must neither complete nor disturb the held load word.
    bus.i_sram_ack = 1'b1; bus.i_sram_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("stray_ack_done", bus.o_done, 0);
      chk("stray_ack_ready", bus.o_ready, 1);
      chk("ld_data_held", bus.o_ld_data, 32'h1357_9BDF);
    end
    bus.i_sram_ack = 1'b0;

    // Reset during SRAM_WAIT, then a late ack.
    bus.i_we = 1'b0; bus.i_addr = 32'h0000_2200; exp_saddr = 13'h0200; exp_bm = 4'h0; bus.i_bmask = 4'h0;
    bus.i_req = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    chk("pre_rst_sram_req", bus.o_sram_req, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_sram_req", bus.o_sram_req, 0);
    chk("mid_rst_ready", bus.o_ready, 1);
    chk("mid_rst_done", bus.o_done, 0);
    chk("mid_rst_ld_data", bus.o_ld_data, 0);
    bus.i_sram_ack = 1'b1; bus.i_sram_rdata = 32'hABCD_EF01;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("late_ack_done", bus.o_done, 0);
      chk("late_ack_sram_req", bus.o_sram_req, 0);
    end
    bus.i_sram_ack = 1'b0;
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
